// File: rtl/eth_10g_st_error_adapter_pipe.sv
// Registered Avalon-ST error adapter: remaps error flags through ERR_MAP, buffers beats in a
// 2-slot skid pipeline and keeps saturating clear-on-read counters per output error bit.
module eth_10g_st_error_adapter_pipe #(
  parameter int                     DATA_W    = 40,
  parameter int                     IN_ERR_W  = 6,
  parameter int                     OUT_ERR_W = 7,
  parameter logic [8*OUT_ERR_W-1:0] ERR_MAP   = 56'hFF_00_01_02_05_04_03,
  parameter int                     CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_data,
  input  logic [IN_ERR_W-1:0]  in_error,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_data,
  output logic [OUT_ERR_W-1:0] out_error,
  input  logic [3:0]           cnt_sel,
  input  logic                 cnt_rd,
  output logic [CNT_W-1:0]     cnt_rdata,
  output logic                 cnt_rvalid
);

  logic [OUT_ERR_W-1:0] mapped;
  logic                 accept;
  logic                 drain;

  logic                 or_valid;
  logic [DATA_W-1:0]    or_data;
  logic [OUT_ERR_W-1:0] or_err;
  logic                 sk_valid;
  logic [DATA_W-1:0]    sk_data;
  logic [OUT_ERR_W-1:0] sk_err;

  logic [CNT_W-1:0]     cnt [OUT_ERR_W];
  logic [CNT_W-1:0]     rd_val;

  // Source indices are resolved at elaboration; out-of-range entries tie the bit low.
  for (genvar k = 0; k < OUT_ERR_W; k++) begin : g_map
    localparam int SRC = int'(ERR_MAP[8*k +: 8]);
    if (SRC < IN_ERR_W) begin : g_src
      assign mapped[k] = in_error[SRC];
    end else begin : g_tie
      assign mapped[k] = 1'b0;
    end
  end

  // A beat moves when valid and ready are both high at a rising edge; in_ready depends only on
  // sk_valid, so there is no combinational path from out_ready back to in_ready.
  assign in_ready  = !sk_valid;
  assign accept    = in_valid & in_ready;
  assign drain     = or_valid & out_ready;
  assign out_valid = or_valid;
  assign out_data  = or_data;
  assign out_error = or_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      or_valid <= 1'b0;
      or_data  <= '0;
      or_err   <= '0;
      sk_valid <= 1'b0;
      sk_data  <= '0;
      sk_err   <= '0;
    end else if (!or_valid || drain) begin
      if (sk_valid) begin
        // SK is full so in_ready is low and nothing is accepted this cycle.
        or_valid <= 1'b1;
        or_data  <= sk_data;
        or_err   <= sk_err;
        sk_valid <= 1'b0;
      end else if (accept) begin
        or_valid <= 1'b1;
        or_data  <= in_data;
        or_err   <= mapped;
      end else begin
        or_valid <= 1'b0;
      end
    end else if (accept) begin
      sk_valid <= 1'b1;
      sk_data  <= in_data;
      sk_err   <= mapped;
    end
  end

  // A read clears its counter but keeps a same-cycle event, so the post-clear value is 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < OUT_ERR_W; k++) cnt[k] <= '0;
    end else begin
      for (int k = 0; k < OUT_ERR_W; k++) begin
        if (cnt_rd && (cnt_sel == 4'(k))) begin
          cnt[k] <= (accept && mapped[k]) ? CNT_W'(1) : '0;
        end else if (accept && mapped[k] && (cnt[k] != {CNT_W{1'b1}})) begin
          cnt[k] <= cnt[k] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    rd_val = '0;
    for (int k = 0; k < OUT_ERR_W; k++) begin
      if (cnt_sel == 4'(k)) rd_val = cnt[k];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_rdata  <= '0;
      cnt_rvalid <= 1'b0;
    end else begin
      cnt_rvalid <= cnt_rd;
      if (cnt_rd) cnt_rdata <= rd_val;
    end
  end

endmodule

// File: tb/tb_eth_10g_st_error_adapter_pipe.sv
// Bench for eth_10g_st_error_adapter_pipe: vector table, backpressure stream with a FIFO
// scoreboard, counter saturation/collision, custom map and mid-stream reset.
module tb_eth_10g_st_error_adapter_pipe;
  localparam int DW = 40;
  localparam int IW = 6;
  localparam int OW = 7;
  localparam int SW = DW + OW;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [IW-1:0] in_error = '0;
  logic          out_ready = 1'b0;
  logic [3:0]    cnt_sel = '0;
  logic          cnt_rd = 1'b0;

  logic          in_ready, out_valid, cnt_rvalid;
  logic [DW-1:0] out_data;
  logic [OW-1:0] out_error;
  logic [3:0]    cnt_rdata;

  logic          in_ready_b, out_valid_b, cnt_rvalid_b;
  logic [DW-1:0] out_data_b;
  logic [OW-1:0] out_error_b;
  logic [15:0]   cnt_rdata_b;

  eth_10g_st_error_adapter_pipe #(.CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_error(in_error),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_error(out_error),
    .cnt_sel(cnt_sel), .cnt_rd(cnt_rd), .cnt_rdata(cnt_rdata), .cnt_rvalid(cnt_rvalid)
  );

  eth_10g_st_error_adapter_pipe #(.ERR_MAP(56'hFF_FF_FF_FF_FF_FF_00)) dut_b (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data), .in_error(in_error),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b), .out_error(out_error_b),
    .cnt_sel(cnt_sel), .cnt_rd(cnt_rd), .cnt_rdata(cnt_rdata_b), .cnt_rvalid(cnt_rvalid_b)
  );

  int errors = 0;
  int checks = 0;
  logic [SW-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Default map written out by hand: out = {0, e0, e1, e2, e5, e4, e3}.
  function automatic logic [OW-1:0] map_default(input logic [IW-1:0] e);
    return {1'b0, e[0], e[1], e[2], e[5], e[4], e[3]};
  endfunction

  // ---------------- scoreboard: sampled mid-cycle, events apply at the next edge
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
    end else begin
      check("in_ready_vs_occupancy", {63'd0, in_ready}, {63'd0, exp_q.size() < 2});
      check("out_valid_vs_occupancy", {63'd0, out_valid}, {63'd0, exp_q.size() != 0});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_beat", {17'd0, out_data, out_error}, 64'd0);
        end else begin
          check("sb_beat", {17'd0, out_data, out_error}, {17'd0, exp_q.pop_front()});
        end
      end
      if (in_valid && in_ready) exp_q.push_back({in_data, map_default(in_error)});
    end
  end

  // ---------------- driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [IW-1:0] e);
    in_valid = 1'b1;
    in_data  = d;
    in_error = e;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) begin
        tick();
        in_valid = 1'b0;
        return;
      end
      tick();
    end
    in_valid = 1'b0;
    checks++;
    errors++;
    $display("FAIL send_timeout: in_ready stayed 0 for 50 cycles");
  endtask

  task automatic read_cnt(input logic [3:0] sel, input logic [3:0] exp, input string name);
    cnt_sel = sel;
    cnt_rd  = 1'b1;
    tick();
    cnt_rd = 1'b0;
    check({name, "_rvalid"}, {63'd0, cnt_rvalid}, 64'd1);
    check(name, {60'd0, cnt_rdata}, {60'd0, exp});
    tick();
    check({name, "_rvalid_pulse"}, {63'd0, cnt_rvalid}, 64'd0);
  endtask

  task automatic clear_cnts();
    for (int k = 0; k < OW; k++) begin
      cnt_sel = 4'(k);
      cnt_rd  = 1'b1;
      tick();
    end
    cnt_rd = 1'b0;
    tick();
  endtask

  typedef struct {
    logic [DW-1:0] data;
    logic [IW-1:0] err;
    logic [OW-1:0] exp_err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int i;
    int cyc;
    logic acc;

    vecs[0] = '{40'h00_0000_0001, 6'b000100, 7'b0001000};
    vecs[1] = '{40'hFF_FFFF_FFFF, 6'b111111, 7'b0111111};
    vecs[2] = '{40'h12_3456_789A, 6'b000000, 7'b0000000};
    vecs[3] = '{40'hA5_A5A5_A5A5, 6'b001000, 7'b0000001};
    vecs[4] = '{40'h5A_5A5A_5A5A, 6'b100000, 7'b0000100};
    vecs[5] = '{40'hDE_ADBE_EF00, 6'b000001, 7'b0100000};

    // ---------------- reset state
    repeat (3) tick();
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_data", {24'd0, out_data}, 64'd0);
    check("rst_out_error", {57'd0, out_error}, 64'd0);
    check("rst_cnt_rdata", {60'd0, cnt_rdata}, 64'd0);
    check("rst_cnt_rvalid", {63'd0, cnt_rvalid}, 64'd0);
    reset = 1'b0;
    tick();
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // ---------------- vector table: one-cycle latency, mapping, data pass-through
    out_ready = 1'b1;
    for (int v = 0; v < 6; v++) begin
      send(vecs[v].data, vecs[v].err);
      check("vec_out_valid", {63'd0, out_valid}, 64'd1);
      check("vec_out_data", {24'd0, out_data}, {24'd0, vecs[v].data});
      check("vec_out_error", {57'd0, out_error}, {57'd0, vecs[v].exp_err});
    end
    tick();

    // ---------------- backpressure stream, out_ready pattern 1,0,0
    i = 0;
    cyc = 0;
    in_valid = 1'b1;
    while (i < 20 && cyc < 300) begin
      out_ready = (cyc % 3 == 0);
      in_data   = 40'd1000 + 40'(i);
      in_error  = 6'(i);
      @(negedge clk);
      acc = in_ready;
      tick();
      if (acc) i++;
      cyc++;
    end
    in_valid = 1'b0;
    check("bp_all_accepted", 64'(i), 64'd20);
    out_ready = 1'b1;
    for (int n = 0; n < 20 && exp_q.size() != 0; n++) tick();
    tick();
    check("bp_drained", 64'(exp_q.size()), 64'd0);

    // ---------------- saturation at 4'hF, then clear-on-read
    clear_cnts();
    for (int n = 0; n < 20; n++) send(40'(n), 6'b000100);
    read_cnt(4'd3, 4'hF, "sat_read");
    read_cnt(4'd3, 4'h0, "sat_reread");

    // ---------------- read/increment collision on counter 0 (undersize)
    clear_cnts();
    for (int n = 0; n < 3; n++) send(40'(n), 6'b001000);
    @(negedge clk);
    check("coll_in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b1;
    in_data  = 40'h77;
    in_error = 6'b001000;
    cnt_sel  = 4'd0;
    cnt_rd   = 1'b1;
    tick();
    in_valid = 1'b0;
    cnt_rd   = 1'b0;
    check("coll_rvalid", {63'd0, cnt_rvalid}, 64'd1);
    check("coll_read", {60'd0, cnt_rdata}, 64'd3);
    tick();
    read_cnt(4'd0, 4'd1, "coll_reread");

    // ---------------- custom map instance and out-of-range counter select
    clear_cnts();
    send(40'hABC, 6'b000001);
    check("cust_out_valid", {63'd0, out_valid_b}, 64'd1);
    check("cust_out_error", {57'd0, out_error_b}, 64'd1);
    check("cust_out_data", {24'd0, out_data_b}, 64'hABC);
    check("dflt_same_beat", {57'd0, out_error}, 64'b0100000);
    cnt_sel = 4'd9;
    cnt_rd  = 1'b1;
    tick();
    cnt_rd = 1'b0;
    check("sel9_rvalid_b", {63'd0, cnt_rvalid_b}, 64'd1);
    check("sel9_rdata_b", {48'd0, cnt_rdata_b}, 64'd0);
    check("sel9_rvalid", {63'd0, cnt_rvalid}, 64'd1);
    check("sel9_rdata", {60'd0, cnt_rdata}, 64'd0);
    tick();
    check("sel9_hold", {60'd0, cnt_rdata}, 64'd0);
    read_cnt(4'd5, 4'd1, "sel9_no_clear");

    // ---------------- reset with both slots full
    out_ready = 1'b0;
    send(40'h111, 6'b000100);
    send(40'h222, 6'b001000);
    @(negedge clk);
    check("full_in_ready", {63'd0, in_ready}, 64'd0);
    check("full_out_data", {24'd0, out_data}, 64'h111);
    tick();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    check("post_rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    for (int k = 0; k < OW; k++) read_cnt(4'(k), 4'd0, "post_rst_cnt");
    out_ready = 1'b1;
    repeat (5) tick();
    check("post_rst_no_stale", {63'd0, out_valid}, 64'd0);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
